// File: rtl/score_disp_pkg.sv
// Shared types, segment codes and constant helpers for the score display path.
// Digit-width helpers are evaluated at elaboration time only.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Active-high {g,f,e,d,c,b,a} codes for decimal 0..9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < n) p = p * 64'd10;
        end
        return p;
    endfunction

    // Decimal digits needed for the largest w-bit value.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int d;
        v = (64'd1 << w) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter with a one-deep newest-wins
// pending slot; a result commits SCORE_W+1 cycles after its load.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W  = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    bin,
    input  logic                  start,
    output logic                  busy,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  ovf,
    output logic                  done
);

    localparam int ACC_DIGITS = (N_DIGITS > dec_digits(SCORE_W)) ? N_DIGITS : dec_digits(SCORE_W);
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CNT_W      = $clog2(SCORE_W);
    localparam longint unsigned P10 = pow10(N_DIGITS);
    localparam longint unsigned LIM = 64'd1 << SCORE_W;
    // A threshold of 2^SCORE_W can never be reached, which disables saturation.
    localparam logic [SCORE_W:0] OVF_TH = (SCORE_W+1)'((P10 < LIM) ? P10 : LIM);

    conv_state_t           state_q, state_d;
    logic [SCORE_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]      acc_q, acc_d, adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [SCORE_W-1:0]    pend_score_q, pend_score_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  load_go;
    logic [SCORE_W-1:0]    load_val;

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_pend_d   = ovf_pend_q;
        pend_score_d = pend_score_q;
        pend_valid_d = pend_valid_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        load_go      = 1'b0;
        load_val     = bin;

        adj = acc_q;
        for (int k = 0; k < ACC_DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (start) load_go = 1'b1;
            end
            SHIFT: begin
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = DONE;
                if (start) begin
                    pend_score_d = bin;
                    pend_valid_d = 1'b1;
                end
            end
            DONE: begin
                bcd_d        = ovf_pend_q ? {N_DIGITS{4'h9}} : acc_q[4*N_DIGITS-1:0];
                ovf_d        = ovf_pend_q;
                done_d       = 1'b1;
                pend_valid_d = 1'b0;
                // A strobe landing on the commit cycle is newer than the held value.
                if (start || pend_valid_q) begin
                    load_go  = 1'b1;
                    load_val = start ? bin : pend_score_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_go) begin
            bin_d      = load_val;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_pend_d = ({1'b0, load_val} >= OVF_TH);
            state_d    = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_pend_q   <= 1'b0;
            pend_score_q <= '0;
            pend_valid_q <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_pend_q   <= ovf_pend_d;
            pend_score_q <= pend_score_d;
            pend_valid_q <= pend_valid_d;
            bcd_q        <= bcd_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Score-to-display engine: sequential BCD conversion, N-digit scan onto one shared
// seven-segment decoder, leading-zero blanking, overflow saturation and game-over blink.
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int N_DIGITS    = 3,
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 2_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  score_valid,
    input  logic                  game_over,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  overflow,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic [6:0]            seg
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic                conv_done;
    logic [REF_W-1:0]    refresh_q, refresh_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [N_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [6:0]          seg_q, seg_d;
    logic                refresh_wrap;
    logic [N_DIGITS-1:0] dig_en;
    logic                upper_nz;
    logic [3:0]          nib;

    bin2bcd_seq #(
        .SCORE_W  (SCORE_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (score),
        .start (score_valid),
        .busy  (busy),
        .bcd   (bcd),
        .ovf   (overflow),
        .done  (conv_done)
    );

    always_comb begin
        refresh_wrap = (refresh_q == REF_W'(REFRESH_DIV - 1));
        refresh_d    = refresh_wrap ? '0 : refresh_q + 1'b1;
        idx_d        = idx_q;
        if (refresh_wrap) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!game_over) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // Walk down from the top digit; a digit stays lit once any digit at or above it is nonzero.
        dig_en   = '1;
        upper_nz = 1'b0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            upper_nz = upper_nz | (bcd[4*k +: 4] != 4'd0);
            if (lz_blank && !upper_nz) dig_en[k] = 1'b0;
        end

        digit_sel_d = blink_phase_d ? '0 : ((N_DIGITS'(1) << idx_d) & dig_en);

        nib   = bcd[4*idx_d +: 4];
        seg_d = seg_q;
        if (refresh_wrap || conv_done) seg_d = (nib <= 4'd9) ? SEG_LUT[nib] : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q     <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digit_sel_q   <= N_DIGITS'(1);
            seg_q         <= 7'h3F;
        end else begin
            refresh_q     <= refresh_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
        end
    end

    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: a 3-digit and a 2-digit instance share stimulus;
// commits are scored against a queue of expected values when busy falls.
module tb_score_display_ctrl;

    localparam int R = 4;

    typedef struct {
        logic [7:0]  score;
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } vec_t;

    typedef struct {
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } exp_t;

    typedef struct {
        logic [11:0] v;
        int          cyc;
    } commit_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  score = 8'd0;
    logic        score_valid = 1'b0;
    logic        game_over = 1'b0;
    logic        lz_blank = 1'b0;

    logic        busy, overflow;
    logic [11:0] bcd;
    logic [2:0]  digit_sel;
    logic [6:0]  seg;
    logic        busy2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  digit_sel2;
    logic [6:0]  seg2;

    int checks = 0;
    int errors = 0;

    exp_t    sb[$];
    commit_t commit_log[$];
    vec_t    vecs[7];
    int      cyc = 0;
    int      busy_run = 0;
    int      last_busy_len = 0;
    logic [11:0] bcd_prev = 12'h000;

    score_display_ctrl #(.SCORE_W(8), .N_DIGITS(3), .REFRESH_DIV(R), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
        .game_over(game_over), .lz_blank(lz_blank), .busy(busy), .overflow(overflow),
        .bcd(bcd), .digit_sel(digit_sel), .seg(seg)
    );

    score_display_ctrl #(.SCORE_W(8), .N_DIGITS(2), .REFRESH_DIV(R), .BLINK_DIV(4)) dut2 (
        .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
        .game_over(game_over), .lz_blank(lz_blank), .busy(busy2), .overflow(overflow2),
        .bcd(bcd2), .digit_sel(digit_sel2), .seg(seg2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] s);
        score       = s;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout at %0t: busy still 1 after %0d cycles", $time, n);
        end
        tick();
    endtask

    // Lock onto the first cycle of digit 0 and check a full scan period.
    task automatic check_scan(input logic [11:0] val);
        logic [2:0] prev;
        logic [2:0] sel_exp;
        logic [3:0] d;
        bit found = 1'b0;
        prev = digit_sel;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (prev == 3'b100 && digit_sel == 3'b001) found = 1'b1;
            else prev = digit_sel;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_sync at %0t: digit_sel 0x%0h never wrapped to 0x1", $time, digit_sel);
        end else begin
            for (int c = 0; c < 3*R; c++) begin
                if (c > 0) @(negedge clk);
                sel_exp = 3'b001 << (c / R);
                d = 4'(val >> (4 * (c / R)));
                chk("scan_sel", {29'd0, digit_sel}, {29'd0, sel_exp});
                chk("scan_seg", {25'd0, seg}, {25'd0, exp_seg(d)});
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bcd !== bcd_prev) begin
            commit_log.push_back('{v: bcd, cyc: cyc});
            bcd_prev = bcd;
        end
        if (reset) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit at %0t: bcd 0x%0h with empty scoreboard", $time, bcd);
            end else begin
                e = sb.pop_front();
                chk("sb_bcd3", {20'd0, bcd}, {20'd0, e.bcd3});
                chk("sb_ovf3", {31'd0, overflow}, {31'd0, e.ovf3});
                chk("sb_bcd2", {24'd0, bcd2}, {24'd0, e.bcd2});
                chk("sb_ovf2", {31'd0, overflow2}, {31'd0, e.ovf2});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [11:0] blink_pat;
        int bad, seen1, n010, n100, busy_seen;

        vecs[0] = '{8'd137, 12'h137, 1'b0, 8'h99, 1'b1};
        vecs[1] = '{8'd255, 12'h255, 1'b0, 8'h99, 1'b1};
        vecs[2] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0};
        vecs[3] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
        vecs[5] = '{8'd100, 12'h100, 1'b0, 8'h99, 1'b1};
        vecs[6] = '{8'd7,   12'h007, 1'b0, 8'h07, 1'b0};

        @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_bcd",   {20'd0, bcd}, 32'd0);
        chk("rst_sel",   {29'd0, digit_sel}, 32'd1);
        chk("rst_seg",   {25'd0, seg}, 32'h3F);
        chk("rst_bcd2",  {24'd0, bcd2}, 32'd0);
        chk("rst_sel2",  {30'd0, digit_sel2}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            sb.push_back('{vecs[i].bcd3, vecs[i].ovf3, vecs[i].bcd2, vecs[i].ovf2});
            strobe(vecs[i].score);
            wait_idle();
            chk("busy_len", last_busy_len, 32'd9);
            check_scan(vecs[i].bcd3);
        end

        lz_blank = 1'b1;
        sb.push_back('{12'h007, 1'b0, 8'h07, 1'b0});
        strobe(8'd7);
        wait_idle();
        bad = 0;
        seen1 = 0;
        repeat (6*R) begin
            @(negedge clk);
            if (digit_sel != 3'b001 && digit_sel != 3'b000) bad++;
            if (digit_sel == 3'b001) seen1++;
        end
        chk("lz7_only_d0", bad, 32'd0);
        chk("lz7_d0_lit", seen1, 32'(2*R));

        sb.push_back('{12'h042, 1'b0, 8'h42, 1'b0});
        strobe(8'd42);
        wait_idle();
        n010 = 0;
        n100 = 0;
        repeat (6*R) begin
            @(negedge clk);
            if (digit_sel == 3'b010) n010++;
            if (digit_sel == 3'b100) n100++;
        end
        chk("lz42_d1_cycles", n010, 32'(2*R));
        chk("lz42_d2_cycles", n100, 32'd0);

        lz_blank = 1'b0;
        sb.push_back('{12'h007, 1'b0, 8'h07, 1'b0});
        strobe(8'd7);
        wait_idle();
        check_scan(12'h007);

        blink_pat = 12'h787;
        game_over = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("blink_on", {31'd0, (digit_sel != 3'b000)}, {31'd0, blink_pat[i]});
        end
        @(posedge clk);
        #1 game_over = 1'b0;
        @(negedge clk);
        chk("blink_last_off", {31'd0, (digit_sel != 3'b000)}, 32'd0);
        @(negedge clk);
        chk("blink_restore", {31'd0, (digit_sel != 3'b000)}, 32'd1);
        tick();

        commit_log.delete();
        score = 8'd12;
        score_valid = 1'b1;
        tick();
        score = 8'd34;
        tick();
        score = 8'd56;
        tick();
        score_valid = 1'b0;
        sb.push_back('{12'h056, 1'b0, 8'h56, 1'b0});
        wait_idle();
        chk("b2b_busy_len", last_busy_len, 32'd18);
        chk("b2b_commits", commit_log.size(), 32'd2);
        if (commit_log.size() == 2) begin
            chk("b2b_first", {20'd0, commit_log[0].v}, 32'h012);
            chk("b2b_second", {20'd0, commit_log[1].v}, 32'h056);
            chk("b2b_gap", commit_log[1].cyc - commit_log[0].cyc, 32'd9);
        end

        score = 8'd12;
        score_valid = 1'b1;
        tick();
        score = 8'd34;
        tick();
        score_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_bcd",  {20'd0, bcd}, 32'd0);
        chk("mid_rst_ovf",  {31'd0, overflow}, 32'd0);
        chk("mid_rst_sel",  {29'd0, digit_sel}, 32'd1);
        chk("mid_rst_seg",  {25'd0, seg}, 32'h3F);
        chk("mid_rst_bcd2", {24'd0, bcd2}, 32'd0);
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || busy2) busy_seen++;
        end
        chk("mid_rst_no_busy", busy_seen, 32'd0);
        chk("mid_rst_bcd_held", {20'd0, bcd}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
